uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Standalone UART transmitter with an input FIFO, serializing 8-bit bytes onto `tx` as 8N1 frames (optionally 8E1). Sits between a byte producer using a valid/ready handshake and the serial pin. It is the TX-only counterpart used opposite our UART receive path. Unlike the combined UART, it queues writes, so producers never wait for a frame to finish unless the FIFO is full.

## Interface
- `UART_BAUD`, default 9600: baud rate.
- `INPUT_CLOCK`, default 50000000: `clk` frequency in Hz.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of 2 and at least 2.
- `clk`, input, 1 bit: the single clock for the block.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `data_in`, input, 8 bits: byte to queue.
- `data_in_valid`, input, 1 bit: `data_in` is offered this cycle.
- `data_in_ready`, output, 1 bit: FIFO can accept a byte.
- `tx`, output, 1 bit: serial line; idles high.
- `busy`, output, 1 bit: a frame is in progress or the FIFO is non-empty.
- `fifo_count`, output, `$clog2(FIFO_DEPTH)+1` bits: number of occupied FIFO entries.

## Operation
- `CLKS_PER_BIT = INPUT_CLOCK / UART_BAUD`, using integer truncation.
  - Must be in the range 2..65535. Elaborate with `$error` otherwise.
  - The bit counter is 16 bits wide.
- Push: a byte is written on any `posedge clk` where `data_in_valid && data_in_ready`.
  - `data_in_ready = (fifo_count != FIFO_DEPTH)`.
  - `data_in_ready` is derived from registers only. It has no combinational path from `data_in_valid`.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY` (only when the macro is defined), `STOP`.
- `IDLE`: `tx`=1. When the FIFO is non-empty:
  - pop the head byte into the shift register;
  - clear the bit counter and bit index;
  - go to `START`.
- `START`: `tx`=0 for `CLKS_PER_BIT` cycles, then go to `DATA` with bit index 0.
- `DATA`: `tx` = `shift[0]`, sending LSB first.
  - Each bit lasts `CLKS_PER_BIT` cycles, then the register shifts right.
  - After bit index 7, go to `PARITY` if enabled, otherwise to `STOP`.
- `STOP`: `tx`=1 for `CLKS_PER_BIT` cycles. Then:
  - if the FIFO is non-empty, pop and go directly to `START` with no idle gap;
  - otherwise go to `IDLE`.
- `busy = (state != IDLE) || (fifo_count != 0)`.
- Push and pop on the same edge: `fifo_count` is unchanged and both operations complete.
- FIFO full: `data_in_ready`=0 and the offered byte is not taken. A pop re-asserts ready on the following cycle.
- Pointers wrap modulo `FIFO_DEPTH`.
- `data_in` may change freely while `data_in_valid` is 0.

## Timing
- Reset values, applied immediately and asynchronously:
  - `tx`=1, state=`IDLE`;
  - FIFO empty: `fifo_count`=0, pointers=0;
  - `busy`=0, `data_in_ready`=1.
- Pushes are ignored while `rst`=1.
- `tx` is registered, with no glitches.
- Latency with an empty FIFO in `IDLE`: a byte pushed at edge k makes `tx` fall after edge k+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frames are contiguous: the next start bit begins on the cycle after the last stop-bit cycle.
- Reset mid-frame:
  - the frame is abandoned and `tx` returns to 1 at once;
  - queued bytes are discarded;
  - no partial frame resumes after reset.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - a `PARITY` state is inserted between `DATA` and `STOP`;
  - `tx = ^byte`, giving even parity, for `CLKS_PER_BIT` cycles;
  - the frame is 11 bits (8E1).
- Undefined: no `PARITY` state or logic, and the frame is 10 bits (8N1).

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` enum;
  - `UART_DATA_BITS` = 8;
  - `UART_CNT_W` = 16.
- One sub-module, `uart_sync_fifo`: parameterized width and depth, synchronous, with async-high `rst`, and `push`/`pop`/`count`/`full`/`empty` ports.
- The FSM, bit counter and shift register live in `uart_tx_fifo`.

## Test plan
Bench parameters: `INPUT_CLOCK`=10000000, `UART_BAUD`=1000000, so `CLKS_PER_BIT`=10.
- Reset, then idle for 100 cycles → `tx`=1, `busy`=0, `data_in_ready`=1, `fifo_count`=0.
- Push 0xA5 once → `tx` falls after 1 edge. The bench samples mid-bit and sees 0, 1,0,1,0,0,1,0,1, 1. The line is low for 10 cycles, the frame lasts 100 cycles, then `busy`=0.
- Push 0x00, 0xFF, 0x3C on consecutive cycles → three contiguous frames with no high gap beyond each stop bit. Decoded output is 0x00, 0xFF, 0x3C. `fifo_count` peaks at 2 after the first pop.
- Hold `data_in_valid`=1 for 20 cycles with an incrementing byte → `data_in_ready` drops when `fifo_count`=8. Exactly 9 bytes are accepted (8 queued + 1 in flight) and all 9 are transmitted in order.
- Assert `rst` 35 cycles into a 0x55 frame with 3 bytes queued → `tx`=1 in the same cycle and `fifo_count`=0. After release, the line stays idle with no frames.
- With `UART_TX_PARITY_EN`, push 0x07 and then 0x03 → each frame is 110 cycles. The parity bit is 1 for 0x07 and 0 for 0x03.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// data/counter widths and a parity helper.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = 16;

  // Transmit FSM states; PARITY exists only in the 8E1 build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous single-clock FIFO with asynchronous active-high reset.
// Pushes while full and pops while empty are ignored. Read data is the
// current head entry, valid whenever empty is low.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH=%0d must be a power of 2 and at least 2", DEPTH);
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Serializes bytes LSB first as 8N1
// frames, or 8E1 when UART_TX_PARITY_EN is defined.
//
// Input handshake: a byte is taken on any rising clk edge where
// data_in_valid && data_in_ready. data_in_ready depends only on registered
// FIFO occupancy (never on data_in_valid); data_in is ignored while
// data_in_valid is low.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int UART_BAUD   = 9600,
  parameter int INPUT_CLOCK = 50000000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [UART_DATA_BITS-1:0]     data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output uart_tx_state_t                o_dbg_state
);

  localparam int CLKS_PER_BIT = INPUT_CLOCK / UART_BAUD;
  localparam logic [UART_CNT_W-1:0] BIT_LAST = UART_CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_baud
    $error("uart_tx_fifo: CLKS_PER_BIT=%0d out of range 2..65535", CLKS_PER_BIT);
  end

  uart_tx_state_t              r_state;
  uart_tx_state_t              w_state_nxt;
  logic [UART_CNT_W-1:0]       r_cnt;
  logic [UART_CNT_W-1:0]       w_cnt_nxt;
  logic [2:0]                  r_idx;
  logic [2:0]                  w_idx_nxt;
  logic [UART_DATA_BITS-1:0]   r_shift;
  logic [UART_DATA_BITS-1:0]   w_shift_nxt;
  logic                        r_tx;
  logic                        w_tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic                        r_par;
  logic                        w_par_nxt;
`endif

  logic                        w_push;
  logic                        w_pop;
  logic [UART_DATA_BITS-1:0]   w_fifo_data;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_bit_done;

  assign data_in_ready = !w_full;
  assign w_push        = data_in_valid && !w_full;
  assign w_bit_done    = (r_cnt == BIT_LAST);

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (data_in),
    .pop     (w_pop),
    .rd_data (w_fifo_data),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Next-state, counter, shifter and registered-tx logic for the frame FSM.
  // tx is computed for the state being entered so the pin is a flop output.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = even_parity(w_fifo_data);
`endif
        end
      end
      START: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            w_tx_nxt  = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            // Chain straight into the next start bit with no idle gap.
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_idx_nxt   = '0;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = even_parity(w_fifo_data);
`endif
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // FSM, bit timing, shifter and tx flops; reset abandons any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign tx          = r_tx;
  assign busy        = (r_state != IDLE) || (w_count != '0);
  assign fifo_count  = w_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at 10 clocks per bit.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int INPUT_CLOCK = 10_000_000;
  localparam int UART_BAUD   = 1_000_000;
  localparam int FIFO_DEPTH  = 8;
  localparam int CPB         = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     data_in = 8'h00;
  logic           data_in_valid = 1'b0;
  logic           data_in_ready;
  logic           tx;
  logic           busy;
  logic [3:0]     fifo_count;
  uart_tx_state_t dbg_state;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .UART_BAUD   (UART_BAUD),
    .INPUT_CLOCK (INPUT_CLOCK),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .tx            (tx),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .o_dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of accepted bytes plus the position within the frame on the line.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      bit acc;
      acc = data_in_valid && (m_q.size() < FIFO_DEPTH);
      if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else m_pos++;
      end
      if (!m_active && m_q.size() > 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (acc) m_q.push_back(data_in);
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("tx", tx, exp_tx());
      check("busy", busy, m_active || (m_q.size() != 0));
      check("ready", data_in_ready, m_q.size() != FIFO_DEPTH);
      check("fifo_count", fifo_count, m_q.size());
    end
  end

  // ---------------- line decoder (mid-bit sampling) ----------------
  logic [7:0]       rx_q[$];
  logic             rx_par_q[$];
  logic [NBITS-1:0] rx_bits;
  logic [NBITS-1:0] last_bits = '0;
  bit               rst_seen = 1'b0;
  int               peak = 0;

  always @(posedge rst) rst_seen = 1'b1;

  always @(negedge clk) begin
    if (fifo_count > peak) peak = fifo_count;
  end

  initial begin : decoder
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (CPB/2) @(negedge clk);
        rx_bits[0] = tx;
        for (int b = 1; b < NBITS; b++) begin
          repeat (CPB) @(negedge clk);
          rx_bits[b] = tx;
        end
        if (!rst_seen) begin
          rx_q.push_back(rx_bits[8:1]);
`ifdef UART_TX_PARITY_EN
          rx_par_q.push_back(rx_bits[9]);
`endif
          last_bits = rx_bits;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      data_in = 8'($urandom_range(0, 255));
    end
  endtask

  // Asserts reset a given number of cycles after the start bit of 0x55
  // with three more bytes queued, then checks the line stays quiet.
  task automatic reset_mid_frame(input int cyc);
    int lows;
    rx_q.delete();
    @(posedge clk); #1; data_in = 8'h55; data_in_valid = 1'b1;
    @(posedge clk); #1; data_in = 8'h11;               // edge k: 0x55 taken
    @(posedge clk); #1; data_in = 8'h22;               // k+1: frame starts
    @(posedge clk); #1; data_in = 8'h33;
    @(posedge clk); #1; data_in_valid = 1'b0;          // after k+3
    check("rst_pre_count", fifo_count, 3);
    repeat (cyc - 3) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("rst_tx", tx, 1);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", data_in_ready, 1);
    check("rst_state", dbg_state, IDLE);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    lows = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    check("rst_after_low_cycles", lows, 0);
    check("rst_after_frames", rx_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int acc;
    logic [7:0] val;
    logic rdy;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_count", fifo_count, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset.
    idle_cycles(100);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("idle_ready", data_in_ready, 1);
    check("idle_count", fifo_count, 0);
    check("idle_state", dbg_state, IDLE);

    // Single byte 0xA5: latency, start width, bit pattern, frame length.
    rx_q.delete();
    @(posedge clk); #1; data_in = 8'hA5; data_in_valid = 1'b1;
    @(posedge clk); #1; data_in_valid = 1'b0; data_in = 8'h3B;   // edge k
    check("a5_tx_after_push", tx, 1);
    @(posedge clk); #1;                                          // k+1
    check("a5_tx_fall", tx, 0);
    for (int i = 2; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 10) check("a5_start_last_cycle", tx, 0);
      if (i == 11) check("a5_bit0", tx, 1);
    end
    check("a5_busy_last_stop", busy, 1);
    @(posedge clk); #1;
    check("a5_busy_done", busy, 0);
    check("a5_frames", rx_q.size(), 1);
    check("a5_byte", rx_q[0], 8'hA5);
`ifdef UART_TX_PARITY_EN
    check("a5_bits", last_bits, 11'h54A);
`else
    check("a5_bits", last_bits, 10'h34A);
`endif

    // Three back-to-back bytes.
    rx_q.delete();
    @(posedge clk); #1; peak = 0; data_in = 8'h00; data_in_valid = 1'b1;
    @(posedge clk); #1; data_in = 8'hFF;
    @(posedge clk); #1; data_in = 8'h3C;
    @(posedge clk); #1; data_in_valid = 1'b0;
    idle_cycles(3 * FRAME + 10);
    check("b2b_frames", rx_q.size(), 3);
    check("b2b_byte0", rx_q[0], 8'h00);
    check("b2b_byte1", rx_q[1], 8'hFF);
    check("b2b_byte2", rx_q[2], 8'h3C);
    check("b2b_peak_count", peak, 2);

    // Hold valid for 20 cycles with an incrementing byte: FIFO fills.
    rx_q.delete();
    acc = 0;
    val = 8'h10;
    @(posedge clk); #1; data_in = val; data_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = data_in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        val = val + 8'd1;
      end
      data_in = val;
    end
    data_in_valid = 1'b0;
    check("full_accepted", acc, 9);
    check("full_ready", data_in_ready, 0);
    check("full_count", fifo_count, 8);
    idle_cycles(9 * FRAME + 20);
    check("full_frames", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("full_byte%0d", i), rx_q[i], 8'h10 + 8'(i));
    end

    // Reset in the middle of a frame with bytes queued.
    reset_mid_frame(35);
    reset_mid_frame(45);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0.
    rx_q.delete();
    rx_par_q.delete();
    @(posedge clk); #1; data_in = 8'h07; data_in_valid = 1'b1;
    @(posedge clk); #1; data_in = 8'h03;
    @(posedge clk); #1; data_in_valid = 1'b0;
    idle_cycles(2 * FRAME + 20);
    check("par_frames", rx_q.size(), 2);
    check("par_byte0", rx_q[0], 8'h07);
    check("par_byte1", rx_q[1], 8'h03);
    check("par_bit0", rx_par_q[0], 1);
    check("par_bit1", rx_par_q[1], 0);
`endif

    idle_cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
